// File: rtl/sweep_checker_ctrl.sv
// Sweep checker: drives 3-bit vectors into a small gate network and
// compares its two responses against internally computed golden values.
module sweep_checker_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       mode,
    input  logic [2:0] vec_sel,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    input  logic       dut_x,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       mode_q;
    logic       exp_x;
    logic       exp_y;
    logic       mismatch;

    assign exp_x    = ~(dut_c ^ (dut_a | dut_b));
    assign exp_y    = dut_a & dut_b;
    assign mismatch = (dut_x != exp_x) || (dut_y != exp_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= 3'd0;
            cnt              <= 4'd0;
            mode_q           <= 1'b0;
            dut_a            <= 1'b0;
            dut_b            <= 1'b0;
            dut_c            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= 4'd0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state            <= DRIVE;
                        busy             <= 1'b1;
                        err_cnt          <= 4'd0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                        idx              <= mode ? vec_sel : 3'd0;
                        mode_q           <= mode;
                    end
                end
                DRIVE: begin
                    {dut_a, dut_b, dut_c} <= idx;
                    cnt                   <= 4'd0;
                    state                 <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    // the comparison is recorded even if abort ends the run here
                    if (mismatch) begin
                        err_cnt <= err_cnt + 4'd1;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= idx;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (mode_q || idx == 3'd7) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    if (!abort) begin
                        done <= 1'b1;
                        pass <= (err_cnt == 4'd0);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (abort && state != IDLE) begin
                state                 <= IDLE;
                busy                  <= 1'b0;
                done                  <= 1'b0;
                {dut_a, dut_b, dut_c} <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_sweep_checker_ctrl.sv
// Bench for sweep_checker_ctrl: two instances (settle 2 and 1) share
// stimulus; a scoreboard queue is drained by a monitor on each done pulse.
module tb_sweep_checker_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       mode;
    logic [2:0] vec_sel;
    logic [1:0] da, db, dc, dx, dy;
    logic [1:0] busy, done, pass, ffv;
    logic [3:0] ec [2];
    logic [2:0] ffvec [2];

    bit [7:0] fx;
    bit [7:0] fy;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int inst;
        int acc;
        int lat;
        int err;
        bit ffv;
        int ffvec;
        bit pass;
    } exp_t;

    exp_t sbq[$];

    int m_err [2];
    bit m_ffv [2];
    int m_ffvec [2];
    bit m_pass [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gold_x(input logic [2:0] v);
        return ~(v[0] ^ (v[2] | v[1]));
    endfunction

    function automatic logic gold_y(input logic [2:0] v);
        return v[2] & v[1];
    endfunction

    // gate network under test: golden behaviour with per-vector flips
    assign dx[0] = gold_x({da[0], db[0], dc[0]}) ^ fx[{da[0], db[0], dc[0]}];
    assign dy[0] = gold_y({da[0], db[0], dc[0]}) ^ fy[{da[0], db[0], dc[0]}];
    assign dx[1] = gold_x({da[1], db[1], dc[1]}) ^ fx[{da[1], db[1], dc[1]}];
    assign dy[1] = gold_y({da[1], db[1], dc[1]}) ^ fy[{da[1], db[1], dc[1]}];

    sweep_checker_ctrl #(.SETTLE_CYC(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mode(mode), .vec_sel(vec_sel),
        .dut_a(da[0]), .dut_b(db[0]), .dut_c(dc[0]),
        .dut_x(dx[0]), .dut_y(dy[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(ec[0]), .first_fail_vec(ffvec[0]),
        .first_fail_valid(ffv[0])
    );

    sweep_checker_ctrl #(.SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mode(mode), .vec_sel(vec_sel),
        .dut_a(da[1]), .dut_b(db[1]), .dut_c(dc[1]),
        .dut_x(dx[1]), .dut_y(dy[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(ec[1]), .first_fail_vec(ffvec[1]),
        .first_fail_valid(ffv[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    function automatic int sc(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // vector k of a run is sampled k+1 vector-periods after acceptance
    function automatic exp_t model(input int i, input bit md,
                                   input logic [2:0] vs, input int ab);
        exp_t e;
        int s = sc(i);
        int n = md ? 1 : 8;
        logic [2:0] v;
        e.inst = i;
        e.acc = 0;
        e.err = 0;
        e.ffv = 1'b0;
        e.ffvec = 0;
        for (int k = 0; k < n; k++) begin
            v = md ? vs : 3'(k);
            if ((ab == 0 || (k + 1) * (s + 2) <= ab) && (fx[v] | fy[v])) begin
                e.err++;
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.ffvec = int'(v);
                end
            end
        end
        e.lat = n * (s + 2) + 1;
        e.pass = (e.err == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        int pos;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) begin
                pos = -1;
                for (int j = 0; j < sbq.size(); j++) begin
                    if (pos < 0 && sbq[j].inst == i) pos = j;
                end
                if (pos < 0) begin
                    chk("unexpected_done", 32'(done[i]), 0);
                end else begin
                    e = sbq[pos];
                    sbq.delete(pos);
                    chk("done_latency", cyc - e.acc, e.lat);
                    chk("done_err_cnt", 32'(ec[i]), e.err);
                    chk("done_pass", 32'(pass[i]), 32'(e.pass));
                    chk("done_ffv", 32'(ffv[i]), 32'(e.ffv));
                    if (e.ffv) chk("done_ffvec", 32'(ffvec[i]), e.ffvec);
                end
            end
        end
    end

    task automatic run(input bit md, input logic [2:0] vs,
                       input int ab, input bit bump);
        exp_t e [2];
        bit killed [2];
        int cnt;
        start = 1'b1;
        mode = md;
        vec_sel = vs;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e[i] = model(i, md, vs, ab);
            e[i].acc = cyc;
            killed[i] = !(ab == 0 || ab > e[i].lat);
            if (!killed[i]) sbq.push_back(e[i]);
            m_pass[i] = killed[i] ? 1'b0 : e[i].pass;
            m_err[i] = e[i].err;
            m_ffv[i] = e[i].ffv;
            if (e[i].ffv) m_ffvec[i] = e[i].ffvec;
            chk("busy_on_accept", 32'(busy[i]), 1);
            chk("clear_on_accept", {pass[i], ec[i], ffv[i]}, 0);
        end
        for (int t = 1; t <= 37; t++) begin
            if (t == ab) abort = 1'b1;
            if (bump && t == 2) start = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (t == 1)
                    chk("drive_vec", {da[i], db[i], dc[i]},
                        md ? 32'(vs) : 0);
                if (t == ab && killed[i]) begin
                    chk("abort_idle",
                        {busy[i], done[i], da[i], db[i], dc[i]}, 0);
                    chk("abort_err_cnt", 32'(ec[i]), m_err[i]);
                    chk("abort_ffv", 32'(ffv[i]), 32'(m_ffv[i]));
                    chk("abort_pass", 32'(pass[i]), 32'(m_pass[i]));
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            cnt = 0;
            foreach (sbq[j]) if (sbq[j].inst == i) cnt++;
            chk("missing_done", cnt, 0);
            chk("hold_busy", 32'(busy[i]), 0);
            chk("hold_err_cnt", 32'(ec[i]), m_err[i]);
            chk("hold_pass", 32'(pass[i]), 32'(m_pass[i]));
            chk("hold_ffv", 32'(ffv[i]), 32'(m_ffv[i]));
            if (m_ffv[i]) chk("hold_ffvec", 32'(ffvec[i]), m_ffvec[i]);
        end
    endtask

    task automatic stuck_x0();
        fy = '0;
        for (int v = 0; v < 8; v++) fx[v] = gold_x(3'(v));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode = 1'b0;
        vec_sel = 3'd0;
        fx = '0;
        fy = '0;
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 0;
            m_ffv[i] = 1'b0;
            m_ffvec[i] = 0;
            m_pass[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk("reset_outputs",
                {da[i], db[i], dc[i], busy[i], done[i], pass[i],
                 ec[i], ffvec[i], ffv[i]}, 0);
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, 3'd0, 0, 1'b0);
        chk("good_sweep_err", 32'(ec[0]), 0);
        chk("good_sweep_pass", 32'(pass[0]), 1);
        chk("good_sweep_ffv", 32'(ffv[0]), 0);

        stuck_x0();
        run(1'b0, 3'd0, 0, 1'b0);
        chk("x_stuck0_err", 32'(ec[0]), 4);
        chk("x_stuck0_ffvec", 32'(ffvec[0]), 0);
        chk("x_stuck0_pass", 32'(pass[0]), 0);

        fx = '0;
        for (int v = 0; v < 8; v++) fy[v] = ~gold_y(3'(v));
        run(1'b0, 3'd0, 0, 1'b0);
        chk("y_stuck1_err", 32'(ec[0]), 6);
        chk("y_stuck1_ffvec", 32'(ffvec[0]), 0);
        chk("y_stuck1_pass", 32'(pass[0]), 0);

        fy = '0;
        run(1'b1, 3'd6, 0, 1'b1);
        chk("single_vec6_pass", 32'(pass[0]), 1);
        chk("single_vec6_err", 32'(ec[0]), 0);

        stuck_x0();
        run(1'b0, 3'd0, 16, 1'b0);
        chk("abort_err_const", 32'(ec[0]), 2);
        chk("abort_ffvec_const", 32'(ffvec[0]), 0);
        chk("abort_busy_const", 32'(busy[0]), 0);

        start = 1'b1;
        mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("mid_reset_outputs",
                {da[i], db[i], dc[i], busy[i], done[i], pass[i],
                 ec[i], ffvec[i], ffv[i]}, 0);
            m_err[i] = 0;
            m_ffv[i] = 1'b0;
            m_pass[i] = 1'b0;
        end
        sbq.delete();
        fx = '0;
        run(1'b0, 3'd0, 0, 1'b0);
        chk("after_reset_pass", 32'(pass[1]), 1);

        for (int r = 0; r < 14; r++) begin
            fx = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom & $urandom);
            fy = 8'($urandom & $urandom & $urandom);
            run(1'($urandom), 3'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 34)) : 0,
                1'($urandom_range(0, 2) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
